uart_fifo_bus: RTL and testbench

Parametrised memory-mapped UART peripheral for the mini-SoC CPU bus. It adds the following over the single-byte UART bus slave:
- TX and RX FIFOs of configurable depth.
- A runtime-programmable baud divisor.
- Sticky error flags and a level interrupt.

It sits on the same `ce`/`we`/`addr`/`din`/`dout` peripheral bus and drives the board `RxD`/`TxD` pins directly, with its own 8N1 TX/RX engines.

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_sync_fifo.sv | 63 ++++++
 rtl/uart_fifo_bus.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_fifo_bus.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART bus peripheral: register map, bit positions,
// engine state encodings and the divisor floor.
package uart_pkg;

    // Word register indices on the peripheral bus
    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_DIV    = 3'd2;
    localparam logic [2:0] ADDR_CLEAR  = 3'd3;
    localparam logic [2:0] ADDR_TXDATA = 3'd4;
    localparam logic [2:0] ADDR_RXDATA = 3'd5;

    // STATUS bit positions
    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_EMPTY    = 2;
    localparam int ST_RX_FULL     = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_FRAME_ERR   = 5;
    localparam int ST_TX_OVERFLOW = 6;
    localparam int ST_TX_BUSY     = 7;

    // CTRL bit positions
    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_EN     = 1;
    localparam int CTRL_RX_IRQ_EN = 2;
    localparam int CTRL_TX_IRQ_EN = 3;

    // CLEAR bit positions
    localparam int CLR_RX_OVERRUN  = 0;
    localparam int CLR_FRAME_ERR   = 1;
    localparam int CLR_TX_OVERFLOW = 2;
    localparam int CLR_TX_FLUSH    = 3;
    localparam int CLR_RX_FLUSH    = 4;

    // Shortest usable bit period; smaller programmed divisors are raised to this
    localparam int MIN_DIV = 4;

    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; used for both the TX and RX queues.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Accept a push into a full FIFO only when a pop frees a slot the same cycle
    // NOTE: every signal written in always_comb is assigned on all paths, so no latch is inferred.
    always_comb begin
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
    end

    // Storage write; flush discards whatever arrives alongside it
    // NOTE: the storage array has no reset; pointers and count alone define its contents.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; flush wins over push and pop
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_bus.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, programmable divisor, sticky
// error flags and a level interrupt.
module uart_fifo_bus
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int DIV_RESET  = 217
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        RxD,
    output logic        TxD,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]       ctrl;
    logic [DIV_W-1:0] div_reg, div_eff;
    logic             rx_overrun, frame_err, tx_overflow;
    logic [4:0]       clr;
    logic [31:0]      status;
    logic             wr, rd, unused_din;

    logic             tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic [7:0]       tx_head;
    logic [CW-1:0]    tx_count;
    logic             rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [7:0]       rx_head;
    logic [CW-1:0]    rx_count;

    tx_state_t        tx_state, tx_next;
    logic [DIV_W-1:0] tx_div, tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_tick, tx_start;

    rx_state_t        rx_state, rx_next;
    logic             rx_s1, rx_s2, rx_prev;
    logic [DIV_W-1:0] rx_div, rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_sample, rx_bad_stop;

    assign unused_din = ^din;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
        .din(din[7:0]), .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
        .din(rx_shift), .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // Bus strobe decode and the effective (floored) bit period
    always_comb begin
        wr       = ce & we;
        rd       = ce & ~we;
        tx_push  = wr && (addr == ADDR_TXDATA);
        rx_pop   = rd && (addr == ADDR_RXDATA);
        clr      = (wr && (addr == ADDR_CLEAR)) ? din[4:0] : 5'd0;
        tx_flush = clr[CLR_TX_FLUSH];
        rx_flush = clr[CLR_RX_FLUSH];
        div_eff  = (div_reg < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_reg;
    end

    // TX next state: a frame starts (and pops) from IDLE or straight out of STOP
    always_comb begin
        tx_tick  = (tx_cnt == tx_div - DIV_W'(1));
        tx_start = ctrl[CTRL_TX_EN] && !tx_empty && !tx_flush;
        tx_next  = tx_state;
        tx_pop   = 1'b0;
        case (tx_state)
            TX_IDLE:  if (tx_start) begin tx_next = TX_START; tx_pop = 1'b1; end
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) begin
                          tx_next = tx_start ? TX_START : TX_IDLE;
                          tx_pop  = tx_start;
                      end
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX datapath: bit timer, shifter, and registered line driver
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_div   <= DIV_W'(DIV_RESET);
            TxD      <= 1'b1;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_div   <= div_eff;
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end else if (tx_state != TX_IDLE) begin
                tx_cnt <= tx_tick ? '0 : tx_cnt + DIV_W'(1);
                if (tx_state == TX_DATA && tx_tick) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + 3'd1;
                end
            end
            case (tx_state)
                TX_START: TxD <= 1'b0;
                TX_DATA:  TxD <= tx_shift[0];
                default:  TxD <= 1'b1;
            endcase
        end
    end

    // RX next state: half-period start check, then one sample per bit period
    always_comb begin
        rx_next     = rx_state;
        rx_push     = 1'b0;
        rx_bad_stop = 1'b0;
        rx_sample   = (rx_state == RX_START) ? (rx_cnt == (rx_div >> 1))
                                             : (rx_cnt == rx_div - DIV_W'(1));
        if (!ctrl[CTRL_RX_EN]) begin
            rx_next = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE:      if (rx_prev && !rx_s2) rx_next = RX_START;
                RX_START:     if (rx_sample) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
                RX_DATA:      if (rx_sample && rx_bit == 3'd7) rx_next = RX_STOP;
                RX_STOP:      if (rx_sample) begin
                                  rx_push     = rx_s2;
                                  rx_bad_stop = !rx_s2;
                                  rx_next     = rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
                              end
                RX_WAIT_HIGH: if (rx_s2) rx_next = RX_IDLE;
                default:      rx_next = RX_IDLE;
            endcase
        end
    end

    // RX datapath: line synchroniser, edge history, bit timer and shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_div   <= DIV_W'(DIV_RESET);
        end else begin
            rx_s1    <= RxD;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
            if (rx_state == RX_IDLE) begin
                rx_cnt <= '0;
                rx_bit <= '0;
                rx_div <= div_eff;
            end else begin
                rx_cnt <= rx_sample ? '0 : rx_cnt + DIV_W'(1);
                if (rx_state == RX_DATA && rx_sample) begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                end
            end
        end
    end

    // STATUS word assembled from live FIFO/engine state and sticky flags
    always_comb begin
        status                 = '0;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_RX_EMPTY]    = rx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_RX_OVERRUN]  = rx_overrun;
        status[ST_FRAME_ERR]   = frame_err;
        status[ST_TX_OVERFLOW] = tx_overflow;
        status[ST_TX_BUSY]     = (tx_state != TX_IDLE);
        status[15:8]           = 8'(rx_count);
        status[23:16]          = 8'(tx_count);
    end

    // Control registers, sticky flags (set beats clear), read port and irq
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl        <= 4'h3;
            div_reg     <= DIV_W'(DIV_RESET);
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
            tx_overflow <= 1'b0;
            dout        <= '0;
            irq         <= 1'b0;
        end else begin
            if (wr && addr == ADDR_CTRL) ctrl    <= din[3:0];
            if (wr && addr == ADDR_DIV)  div_reg <= din[DIV_W-1:0];

            if (rx_push && rx_full && !rx_pop && !rx_flush) rx_overrun <= 1'b1;
            else if (clr[CLR_RX_OVERRUN])                   rx_overrun <= 1'b0;
            if (rx_bad_stop)                                frame_err <= 1'b1;
            else if (clr[CLR_FRAME_ERR])                    frame_err <= 1'b0;
            if (tx_push && tx_full && !tx_pop && !tx_flush) tx_overflow <= 1'b1;
            else if (clr[CLR_TX_OVERFLOW])                  tx_overflow <= 1'b0;

            if (rd) begin
                case (addr)
                    ADDR_STATUS: dout <= status;
                    ADDR_CTRL:   dout <= 32'(ctrl);
                    ADDR_DIV:    dout <= 32'(div_reg);
                    ADDR_RXDATA: dout <= rx_empty ? 32'd0 : 32'(rx_head);
                    default:     dout <= 32'd0;
                endcase
            end

            irq <= (ctrl[CTRL_RX_IRQ_EN] & (~rx_empty | rx_overrun | frame_err))
                 | (ctrl[CTRL_TX_IRQ_EN] & tx_empty);
        end
    end

endmodule

// File: tb/tb_uart_fifo_bus.sv
// Self-checking bench for uart_fifo_bus: randomized payloads against a
// queue-based model of the FIFOs, flags and serial frame format.
module tb_uart_fifo_bus;
    localparam int DEPTH = 16;
    localparam int DIV   = 8;

    localparam logic [2:0] A_STATUS = 3'd0;
    localparam logic [2:0] A_CTRL   = 3'd1;
    localparam logic [2:0] A_DIV    = 3'd2;
    localparam logic [2:0] A_CLEAR  = 3'd3;
    localparam logic [2:0] A_TXDATA = 3'd4;
    localparam logic [2:0] A_RXDATA = 3'd5;

    logic        clk = 1'b0;
    logic        rst, ce, we, RxD, TxD, irq;
    logic [2:0]  addr;
    logic [31:0] din, dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int irq_rise = -1;
    logic irq_prev = 1'b0;

    logic [7:0] rx_model[$];
    logic [7:0] tx_model[$];

    uart_fifo_bus #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .DIV_RESET(217)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .din(din),
        .dout(dout), .RxD(RxD), .TxD(TxD), .irq(irq)
    );

    always #5 clk = ~clk;

    // Cycle counter and irq rising-edge timestamp, sampled well clear of the edge
    always @(posedge clk) begin
        #2;
        cyc = cyc + 1;
        if (irq === 1'b1 && irq_prev !== 1'b1) irq_rise = cyc;
        irq_prev = irq;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    // Expected STATUS word from model-level quantities
    function automatic logic [31:0] exp_status(input int rx_n, input int tx_n,
                                               input bit ovr, input bit fe,
                                               input bit txo, input bit busy);
        logic [31:0] s;
        s        = '0;
        s[0]     = (tx_n == DEPTH);
        s[1]     = (tx_n == 0);
        s[2]     = (rx_n == 0);
        s[3]     = (rx_n == DEPTH);
        s[4]     = ovr;
        s[5]     = fe;
        s[6]     = txo;
        s[7]     = busy;
        s[15:8]  = rx_n[7:0];
        s[23:16] = tx_n[7:0];
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = a; din = d;
        tick(1);
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = a;
        tick(1);
        ce = 1'b0;
        d = dout;
    endtask

    // Drive one 8N1 frame onto RxD at DIV clocks per bit; the line is left at the stop value
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RxD = f[i];
            tick(DIV);
        end
    endtask

    task automatic line_idle(input int n);
        RxD = 1'b1;
        tick(n);
    endtask

    // Decode one frame from TxD by mid-bit sampling; got=0 if no valid frame appears in time
    task automatic tx_capture(input int bitlen, output logic [7:0] b, output bit got);
        int budget;
        b = '0;
        got = 1'b0;
        budget = 0;
        while (TxD !== 1'b0 && budget < 400) begin
            tick(1);
            budget++;
        end
        if (TxD !== 1'b0) return;
        tick(bitlen / 2);
        if (TxD !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            tick(bitlen);
            b[i] = TxD;
        end
        tick(bitlen);
        got = (TxD === 1'b1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; din = '0; RxD = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++;
        if (TxD !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", TxD); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h6) begin errors++; $display("FAIL reset_status got %h want %h", d, 32'h6); end
        bus_read(A_CTRL, d);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL reset_ctrl got %h want %h", d, 32'h3); end
        bus_read(A_DIV, d);
        checks++;
        if (d !== 32'd217) begin errors++; $display("FAIL reset_div got %0d want 217", d); end
        bus_read(A_RXDATA, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_rxdata_empty got %h want 0", d); end
    endtask

    task automatic test_registers();
        logic [31:0] d;
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reg6_read got %h want 0", d); end
        bus_read(3'd7, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reg7_read got %h want 0", d); end
        bus_write(A_DIV, 32'd8);
        bus_read(A_DIV, d);
        checks++;
        if (d !== 32'd8) begin errors++; $display("FAIL div_readback got %0d want 8", d); end
    endtask

    task automatic test_tx_pair();
        logic [19:0] bits;
        logic [31:0] d;
        int bad;
        bits = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
        bus_write(A_TXDATA, 32'hA5);
        bus_write(A_TXDATA, 32'h3C);
        checks++;
        if (TxD !== 1'b1) begin errors++; $display("FAIL tx_latency_early got %b want 1", TxD); end
        for (int k = 0; k < 20; k++) begin
            bad = 0;
            for (int c = 0; c < DIV; c++) begin
                tick(1);
                if (TxD !== bits[k]) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL tx_pair_bit%0d wrong cycles %0d want level %b for %0d clocks", k, bad, bits[k], DIV);
            end
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(0, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL tx_pair_done_status got %h want %h", d, exp_status(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_rx_single();
        logic [31:0] d;
        int start;
        bus_write(A_CTRL, 32'h7);
        tick(2);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_idle got %b want 0", irq); end
        irq_rise = -1;
        start = cyc;
        send_rx(8'h5A, 1'b1);
        line_idle(6);
        checks++;
        if (irq_rise < start + 76 || irq_rise > start + 88) begin
            errors++; $display("FAIL rx_irq_rise_time got offset %0d want 76..88", irq_rise - start);
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(1, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL rx_single_status got %h want %h", d, exp_status(1, 0, 0, 0, 0, 0));
        end
        bus_read(A_RXDATA, d);
        checks++;
        if (d !== 32'h5A) begin errors++; $display("FAIL rx_single_data got %h want %h", d, 32'h5A); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq_lag got %b want 1", irq); end
        tick(1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_fall got %b want 0", irq); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(0, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL rx_single_empty got %h want %h", d, exp_status(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        logic [7:0]  b;
        bit ovr;
        ovr = 1'b0;
        bus_write(A_CTRL, 32'h3);
        rx_model.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            line_idle(2);
            if (rx_model.size() < DEPTH) rx_model.push_back(b);
            else ovr = 1'b1;
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(rx_model.size(), 0, ovr, 0, 0, 0)) begin
            errors++; $display("FAIL rx_overrun_status got %h want %h", d, exp_status(rx_model.size(), 0, ovr, 0, 0, 0));
        end
        bus_write(A_CLEAR, 32'h1);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(rx_model.size(), 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL rx_overrun_clear got %h want %h", d, exp_status(rx_model.size(), 0, 0, 0, 0, 0));
        end
        for (int i = 0; i < DEPTH; i++) begin
            bus_read(A_RXDATA, d);
            b = rx_model.pop_front();
            checks++;
            if (d !== 32'(b)) begin errors++; $display("FAIL rx_fifo_byte%0d got %h want %h", i, d, b); end
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(0, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL rx_drained_status got %h want %h", d, exp_status(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] d;
        send_rx(8'h11, 1'b0);
        tick(20);
        line_idle(4);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(0, 0, 0, 1, 0, 0)) begin
            errors++; $display("FAIL frame_err_status got %h want %h", d, exp_status(0, 0, 0, 1, 0, 0));
        end
        send_rx(8'h22, 1'b1);
        line_idle(4);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(1, 0, 0, 1, 0, 0)) begin
            errors++; $display("FAIL frame_err_recover_status got %h want %h", d, exp_status(1, 0, 0, 1, 0, 0));
        end
        bus_read(A_RXDATA, d);
        checks++;
        if (d !== 32'h22) begin errors++; $display("FAIL frame_err_next_byte got %h want %h", d, 32'h22); end
        bus_write(A_CLEAR, 32'h2);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(0, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL frame_err_clear got %h want %h", d, exp_status(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        logic [7:0]  b, exp_b;
        bit got, txo;
        int lows;
        txo = 1'b0;
        bus_write(A_CTRL, 32'h2);
        tx_model.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            bus_write(A_TXDATA, 32'(b));
            if (tx_model.size() < DEPTH) tx_model.push_back(b);
            else txo = 1'b1;
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(0, tx_model.size(), 0, 0, txo, 0)) begin
            errors++; $display("FAIL tx_overflow_status got %h want %h", d, exp_status(0, tx_model.size(), 0, 0, txo, 0));
        end
        checks++;
        if (TxD !== 1'b1) begin errors++; $display("FAIL tx_disabled_line got %b want 1", TxD); end
        bus_write(A_CTRL, 32'h3);
        for (int i = 0; i < DEPTH; i++) begin
            tx_capture(DIV, b, got);
            exp_b = tx_model.pop_front();
            checks++;
            if (!got || b !== exp_b) begin
                errors++; $display("FAIL tx_frame%0d got %h (valid %0d) want %h", i, b, got, exp_b);
            end
        end
        lows = 0;
        for (int c = 0; c < 150; c++) begin
            tick(1);
            if (TxD !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin errors++; $display("FAIL tx_extra_frame low clocks %0d want 0", lows); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(0, 0, 0, 0, txo, 0)) begin
            errors++; $display("FAIL tx_overflow_sticky got %h want %h", d, exp_status(0, 0, 0, 0, txo, 0));
        end
        bus_write(A_CLEAR, 32'h4);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(0, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL tx_overflow_clear got %h want %h", d, exp_status(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_flush_irq();
        logic [31:0] d;
        bus_write(A_CTRL, 32'hA);
        tick(2);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL tx_irq_empty got %b want 1", irq); end
        for (int i = 0; i < 3; i++) bus_write(A_TXDATA, 32'($urandom_range(0, 255)));
        tick(2);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL tx_irq_pending got %b want 0", irq); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(0, 3, 0, 0, 0, 0)) begin
            errors++; $display("FAIL tx_queued_status got %h want %h", d, exp_status(0, 3, 0, 0, 0, 0));
        end
        bus_write(A_CLEAR, 32'h8);
        tick(2);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL tx_irq_after_flush got %b want 1", irq); end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== exp_status(0, 0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL tx_flush_status got %h want %h", d, exp_status(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_min_div();
        logic [31:0] d;
        logic [7:0]  b, exp_b;
        bit got;
        bus_write(A_CTRL, 32'h3);
        bus_write(A_DIV, 32'd2);
        bus_read(A_DIV, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL div_raw_readback got %0d want 2", d); end
        exp_b = 8'($urandom);
        bus_write(A_TXDATA, 32'(exp_b));
        tx_capture(4, b, got);
        checks++;
        if (!got || b !== exp_b) begin
            errors++; $display("FAIL tx_min_div_frame got %h (valid %0d) want %h", b, got, exp_b);
        end
        bus_write(A_DIV, 32'd8);
    endtask

    initial begin
        test_reset();
        test_registers();
        test_tx_pair();
        test_rx_single();
        test_rx_overrun();
        test_frame_err();
        test_tx_overflow();
        test_flush_irq();
        test_min_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
